mem_stage_sram_ctrl: RTL and testbench

- Sequences the MEM-stage data access issued by the execute stage (MEM_R/MEM_W, ALU result as address, Rm value as store data) onto an external 16-bit asynchronous SRAM.
- Each 32-bit word is transferred as two 16-bit halves, low half first.
- Holds `ready` low while busy so the hazard/freeze logic stalls the whole pipeline until the access finishes.

---
 rtl/mem_stage_sram_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//   Carries out the MEM-stage load/store issued by the execute stage on an
//   external 16-bit asynchronous SRAM. Each 32-bit word moves as two 16-bit
//   halves, low half first. Each half is held for ACCESS_CYC cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        store request (MEM_W)
//   rd_en        load request (MEM_R)
//   address      byte address (ALU result)
//   write_data   store data (Rm value)
//   read_data    registered load result
//   ready        1 = no access pending, or access finishing this cycle
//   sram_addr    SRAM halfword address
//   sram_dq_out  data driven toward the SRAM
//   sram_dq_oe   1 = sram_dq_out owns the bus (tristate built above)
//   sram_dq_in   data read back from the SRAM bus
//   sram_we_n    SRAM write enable, active low
//
// Handshake: the pipeline presents wr_en/rd_en plus address/data and holds
// them while ready=0. A request is accepted in IDLE, and ready drops in that
// same cycle. ready=1 in DONE marks completion, and the pipeline advances on
// that edge. Requests are only sampled in IDLE. Any changes after capture
// are ignored.
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned SRAM_AW    = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int unsigned    CW   = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CW-1:0]  LAST = CW'(ACCESS_CYC - 1);
  localparam logic [31:0]    BASE = 32'(BASE_ADDR);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_wr;
  logic [SRAM_AW-1:0] r_base;
  logic [31:0]        r_wdata;

  logic               w_req;
  logic               w_last;
  logic [SRAM_AW-1:0] w_base;

  assign w_req  = wr_en | rd_en;
  assign w_last = (r_cnt == LAST);
  // Word index doubled gives the halfword address of the low half.
  // The subtraction wraps modulo 2^32. Bits [1:0] of address drop out.
  assign w_base = SRAM_AW'(((address - BASE) >> 2) << 1);

  assign ready = ((r_state == IDLE) && !w_req) || (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // A write wins when both strobes are set.
            r_is_wr   <= wr_en;
            r_base    <= w_base;
            r_wdata   <= write_data;
            r_cnt     <= '0;
            r_state   <= LOW;
            // Outputs are registered, so load the LOW-phase bus values now.
            sram_addr  <= w_base;
            sram_dq_oe <= wr_en;
            sram_we_n  <= ~wr_en;
            if (wr_en) sram_dq_out <= write_data[15:0];
          end
        end
        LOW: begin
          if (w_last) begin
            if (!r_is_wr) read_data[15:0] <= sram_dq_in;
            r_cnt     <= '0;
            r_state   <= HIGH;
            sram_addr <= r_base + SRAM_AW'(1);
            if (r_is_wr) sram_dq_out <= r_wdata[31:16];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (w_last) begin
            if (!r_is_wr) read_data[31:16] <= sram_dq_in;
            r_cnt      <= '0;
            r_state    <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: default ACCESS_CYC=2, dut1: ACCESS_CYC=1
  logic        wr_en0, rd_en0, wr_en1, rd_en1;
  logic [31:0] address0, write_data0, address1, write_data1;
  logic [31:0] read_data0, read_data1;
  logic        ready0, ready1;
  logic [17:0] sram_addr0, sram_addr1;
  logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
  logic        dq_oe0, dq_oe1, we_n0, we_n1;

  // Read-only SRAM image (preloaded). Writes are checked on the bus.
  logic [15:0] mem [16];
  assign dq_in0 = mem[sram_addr0[3:0]];
  assign dq_in1 = mem[sram_addr1[3:0]];

  mem_stage_sram_ctrl dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0),
    .address(address0), .write_data(write_data0), .read_data(read_data0),
    .ready(ready0), .sram_addr(sram_addr0), .sram_dq_out(dq_out0),
    .sram_dq_oe(dq_oe0), .sram_dq_in(dq_in0), .sram_we_n(we_n0)
  );

  mem_stage_sram_ctrl #(.ACCESS_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
    .address(address1), .write_data(write_data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(dq_out1),
    .sram_dq_oe(dq_oe1), .sram_dq_in(dq_in1), .sram_we_n(we_n1)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sampled view of the selected DUT
  logic        s_ready, s_we_n, s_oe;
  logic [17:0] s_addr;
  logic [15:0] s_dq;
  logic [31:0] s_rd;

  task automatic sample(input int sel);
    s_ready = sel ? ready1     : ready0;
    s_we_n  = sel ? we_n1      : we_n0;
    s_oe    = sel ? dq_oe1     : dq_oe0;
    s_addr  = sel ? sram_addr1 : sram_addr0;
    s_dq    = sel ? dq_out1    : dq_out0;
    s_rd    = sel ? read_data1 : read_data0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      wr_en0 = wr; rd_en0 = rd; address0 = addr; write_data0 = data;
    end else begin
      wr_en1 = wr; rd_en1 = rd; address1 = addr; write_data1 = data;
    end
  endtask

  // Called just after a rising edge (cycle 0). Returns just after the edge
  // that ends DONE, with the request dropped.
  task automatic access(input int sel, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit perturb);
    int          acyc;
    logic [17:0] base;
    logic [3:0]  lo_i, hi_i;
    logic [31:0] exp_rd;
    logic        hi;
    acyc = (sel != 0) ? 1 : 2;
    base = 18'(((addr - 32'd1024) >> 2) << 1);
    lo_i = base[3:0];
    hi_i = lo_i + 4'd1;
    if (wr) exp_rd = model_rd[sel];
    else    exp_rd = {mem[hi_i], mem[lo_i]};
    model_rd[sel] = exp_rd;
    exp_q.push_back(exp_rd);

    drive(sel, wr, rd, addr, data);
    @(negedge clk); sample(sel);
    check("ready_fall", 32'(s_ready), 32'd0);
    for (int c = 1; c <= 2 * acyc; c++) begin
      @(posedge clk); #1;
      if (perturb && c == 1) drive(sel, 1'b0, rd, 32'd2000, ~data);
      @(negedge clk); sample(sel);
      hi = (c > acyc);
      check("busy_ready", 32'(s_ready), 32'd0);
      check("sram_addr", 32'(s_addr), 32'(base + 18'(hi)));
      check("we_n", 32'(s_we_n), 32'(!wr));
      check("dq_oe", 32'(s_oe), 32'(wr));
      if (wr) check("dq_out", 32'(s_dq), 32'(hi ? data[31:16] : data[15:0]));
    end
    @(posedge clk); #1;
    @(negedge clk); sample(sel);
    check("done_ready", 32'(s_ready), 32'd1);
    check("done_we_n", 32'(s_we_n), 32'd1);
    check("done_oe", 32'(s_oe), 32'd0);
    check("read_data", s_rd, exp_q.pop_front());
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'hA5A5; mem[1] = 16'h5A5A;
    mem[2] = 16'h1234; mem[3] = 16'h5678;
    mem[6] = 16'h0BAD; mem[7] = 16'hF00D;
    model_rd[0] = '0; model_rd[1] = '0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk); sample(0);
    check("rst_read_data", s_rd, 32'd0);
    check("rst_we_n", 32'(s_we_n), 32'd1);
    check("rst_oe", 32'(s_oe), 32'd0);
    check("rst_addr", 32'(s_addr), 32'd0);
    check("rst_dq_out", 32'(s_dq), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); sample(0);
    check("idle_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // write then read
    access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    // both strobes: write wins, read_data untouched
    access(0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    // request changes after capture are ignored
    access(0, 1'b1, 1'b0, 32'd1040, 32'h13572468, 1'b1);
    // address below BASE_ADDR wraps
    access(0, 1'b0, 1'b1, 32'd0, 32'h0, 1'b0);

    // reset during HIGH of a read
    drive(0, 1'b0, 1'b1, 32'd1036, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 sample(0);
    check("midrst_we_n", 32'(s_we_n), 32'd1);
    check("midrst_oe", 32'(s_oe), 32'd0);
    check("midrst_read_data", s_rd, 32'd0);
    check("midrst_addr", 32'(s_addr), 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 sample(0);
    check("midrst_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    model_rd[0] = '0; model_rd[1] = '0;
    @(posedge clk); #1;
    @(negedge clk); sample(0);
    check("post_rst_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // ACCESS_CYC=1, back-to-back reads
    access(1, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);

    // a few random reads on each instance
    for (int k = 0; k < 6; k++) begin
      access(k % 2, 1'b0, 1'b1, 32'd1024 + 32'($urandom_range(0, 3)) * 4, 32'h0, 1'b0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
